// File: rtl/controle_de_excecao_pkg.sv
// ============================================================================
// Module   : controle_de_excecao_pkg
// Purpose  : Shared state encoding and constants for the overflow-exception
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package controle_de_excecao_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      REQUEST    = 2'd1,
      IN_HANDLER = 2'd2,
      ILLEGAL    = 2'd3
   } state_t;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;
   localparam int          PC_INCREMENT       = 4;

endpackage

`default_nettype wire

// File: rtl/controle_de_excecao_contador_saturado.sv
// ============================================================================
// Module   : contador_saturado
// Purpose  : Parameterised saturating up-counter with enable, async reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_saturado #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/controle_de_excecao.sv
// ============================================================================
// Module   : controle_de_excecao
// Purpose  : ALU flag register and overflow-exception sequencer (EPC capture,
//            redirect request, handler tracking until return-from-exception).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_de_excecao
   import controle_de_excecao_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEFAULT),
   parameter int               CNT_WIDTH  = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Flag_Valid,
   input  logic                 Overflow,
   input  logic                 Zero,
   input  logic [WIDTH-1:0]     PC_Atual,
   input  logic                 Exc_Ack,
   input  logic                 Eret,
   output logic                 Zero_Reg,
   output logic                 Overflow_Reg,
   output logic                 Block_Write,
   output logic                 Exc_Req,
   output logic [WIDTH-1:0]     PC_Vector,
   output logic [WIDTH-1:0]     EPC,
   output logic [WIDTH-1:0]     Return_PC,
   output logic                 Nested,
   output logic [CNT_WIDTH-1:0] Ovf_Count,
   output logic                 Busy
);

   state_t state;
   state_t state_next;
   logic   ovf_evt;

   assign ovf_evt     = Flag_Valid & Overflow;
   assign Block_Write = ovf_evt;
   assign PC_Vector   = EXC_VECTOR;
   assign Return_PC   = EPC + WIDTH'(PC_INCREMENT);
   assign Exc_Req     = (state == REQUEST);
   assign Busy        = (state != IDLE);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Overflows seen outside IDLE are counted but never raise a second request.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:       if (ovf_evt) state_next = REQUEST;
         REQUEST:    if (Exc_Ack) state_next = IN_HANDLER;
         IN_HANDLER: if (Eret)    state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Zero_Reg     <= 1'b0;
         Overflow_Reg <= 1'b0;
         EPC          <= '0;
         Nested       <= 1'b0;
      end else begin
         if (Flag_Valid) begin
            Zero_Reg     <= Zero;
            Overflow_Reg <= Overflow;
         end
         if ((state == IDLE) && ovf_evt) begin
            EPC <= PC_Atual;
         end
         if (state == IN_HANDLER) begin
            if (Eret) begin
               Nested <= 1'b0;
            end else if (ovf_evt) begin
               Nested <= 1'b1;
            end
         end
      end
   end

   contador_saturado #(
      .WIDTH (CNT_WIDTH)
   ) u_ovf_count (
      .clk   (Clock),
      .rst   (Reset),
      .en    (ovf_evt),
      .count (Ovf_Count)
   );

endmodule

`default_nettype wire

// File: tb/tb_controle_de_excecao.sv
// ============================================================================
// Module   : tb_controle_de_excecao
// Purpose  : Self-checking bench for controle_de_excecao.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controle_de_excecao;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Flag_Valid, Overflow, Zero, Exc_Ack, Eret;
   logic [31:0] PC_Atual;
   logic        Zero_Reg, Overflow_Reg, Block_Write, Exc_Req, Nested, Busy;
   logic [31:0] PC_Vector, EPC, Return_PC;
   logic [7:0]  Ovf_Count;

   always #5 Clock = ~Clock;

   controle_de_excecao #(
      .WIDTH      (32),
      .EXC_VECTOR (32'h0000_0080),
      .CNT_WIDTH  (8)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .Flag_Valid   (Flag_Valid),
      .Overflow     (Overflow),
      .Zero         (Zero),
      .PC_Atual     (PC_Atual),
      .Exc_Ack      (Exc_Ack),
      .Eret         (Eret),
      .Zero_Reg     (Zero_Reg),
      .Overflow_Reg (Overflow_Reg),
      .Block_Write  (Block_Write),
      .Exc_Req      (Exc_Req),
      .PC_Vector    (PC_Vector),
      .EPC          (EPC),
      .Return_PC    (Return_PC),
      .Nested       (Nested),
      .Ovf_Count    (Ovf_Count),
      .Busy         (Busy)
   );

   typedef struct {
      logic [4:0]  in_bits;   // {fv, ov, z, ack, eret}
      logic [31:0] pc;
      logic [4:0]  out_bits;  // {req, busy, nested, zero_reg, ovf_reg}
      logic [31:0] epc;
      logic [7:0]  cnt;
   } vec_t;

   typedef struct {
      logic        req, busy, nst, zr, orr;
      logic [31:0] epc, rpc;
      logic [7:0]  cnt;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[16];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: 0 = idle, 1 = request, 2 = in handler
   int          m_state = 0;
   logic        m_zr = 1'b0, m_or = 1'b0, m_nst = 1'b0;
   logic [31:0] m_epc = 32'h0;
   logic [7:0]  m_cnt = 8'h0;

   function automatic vec_t mk(input logic [4:0] ib, input logic [31:0] pc,
                               input logic [4:0] ob, input logic [31:0] epc,
                               input logic [7:0] cnt);
      vec_t v;
      v.in_bits = ib; v.pc = pc; v.out_bits = ob; v.epc = epc; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_zr = 1'b0; m_or = 1'b0; m_nst = 1'b0;
      m_epc = 32'h0; m_cnt = 8'h0;
   endtask

   task automatic model_step(input logic fv, ov, z, ack, eret, input logic [31:0] pc);
      exp_t e;
      logic evt;
      evt = fv & ov;
      if (fv) begin m_zr = z; m_or = ov; end
      if (evt && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      case (m_state)
         0: if (evt) begin m_epc = pc; m_state = 1; end
         1: if (ack) m_state = 2;
         default: if (eret) begin m_state = 0; m_nst = 1'b0; end
                  else if (evt) m_nst = 1'b1;
      endcase
      e.req = (m_state == 1); e.busy = (m_state != 0); e.nst = m_nst;
      e.zr = m_zr; e.orr = m_or; e.epc = m_epc; e.rpc = m_epc + 32'd4; e.cnt = m_cnt;
      sb.push_back(e);
   endtask

   task automatic sb_compare();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk("exc_req",      32'(Exc_Req),      32'(e.req));
      chk("busy",         32'(Busy),         32'(e.busy));
      chk("nested",       32'(Nested),       32'(e.nst));
      chk("zero_reg",     32'(Zero_Reg),     32'(e.zr));
      chk("overflow_reg", 32'(Overflow_Reg), 32'(e.orr));
      chk("epc",          EPC,               e.epc);
      chk("return_pc",    Return_PC,         e.rpc);
      chk("ovf_count",    32'(Ovf_Count),    32'(e.cnt));
      chk("pc_vector",    PC_Vector,         32'h0000_0080);
   endtask

   // One cycle: inputs set at negedge, Block_Write checked combinationally,
   // registered outputs checked 1 time unit after the next rising edge.
   task automatic drive(input logic fv, ov, z, ack, eret, input logic [31:0] pc);
      @(negedge Clock);
      Flag_Valid = fv; Overflow = ov; Zero = z; Exc_Ack = ack; Eret = eret; PC_Atual = pc;
      #1;
      chk("block_write", 32'(Block_Write), 32'(fv & ov));
      model_step(fv, ov, z, ack, eret, pc);
      @(posedge Clock);
      #1;
      sb_compare();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(5'b10100, 32'h0,         5'b00010, 32'h0,         8'd0);
      vecs[1]  = mk(5'b11000, 32'h0000_0040, 5'b11001, 32'h0000_0040, 8'd1);
      vecs[2]  = mk(5'b00000, 32'h0,         5'b11001, 32'h0000_0040, 8'd1);
      vecs[3]  = mk(5'b00000, 32'h0,         5'b11001, 32'h0000_0040, 8'd1);
      vecs[4]  = mk(5'b00010, 32'h0,         5'b01001, 32'h0000_0040, 8'd1);
      vecs[5]  = mk(5'b11000, 32'h0000_0100, 5'b01101, 32'h0000_0040, 8'd2);
      vecs[6]  = mk(5'b00000, 32'h0,         5'b01101, 32'h0000_0040, 8'd2);
      vecs[7]  = mk(5'b00001, 32'h0,         5'b00001, 32'h0000_0040, 8'd2);
      vecs[8]  = mk(5'b10100, 32'h0,         5'b00010, 32'h0000_0040, 8'd2);
      vecs[9]  = mk(5'b01000, 32'h0,         5'b00010, 32'h0000_0040, 8'd2);
      vecs[10] = mk(5'b00011, 32'h0,         5'b00010, 32'h0000_0040, 8'd2);
      vecs[11] = mk(5'b11000, 32'hFFFF_FFFC, 5'b11001, 32'hFFFF_FFFC, 8'd3);
      vecs[12] = mk(5'b11110, 32'h0000_0200, 5'b01011, 32'hFFFF_FFFC, 8'd4);
      vecs[13] = mk(5'b11001, 32'h0000_0300, 5'b00001, 32'hFFFF_FFFC, 8'd5);
      vecs[14] = mk(5'b11000, 32'h0000_0400, 5'b11001, 32'h0000_0400, 8'd6);
      vecs[15] = mk(5'b00001, 32'h0,         5'b11001, 32'h0000_0400, 8'd6);

      // Reset held with an overflow present on the inputs
      Reset = 1'b1; Flag_Valid = 1'b1; Overflow = 1'b1; Zero = 1'b1;
      Exc_Ack = 1'b0; Eret = 1'b0; PC_Atual = 32'h0000_0040;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock);
         #1;
         chk("rst_block_write", 32'(Block_Write), 32'd1);
         chk("rst_exc_req",     32'(Exc_Req),     32'd0);
         chk("rst_busy",        32'(Busy),        32'd0);
         chk("rst_zero_reg",    32'(Zero_Reg),    32'd0);
         chk("rst_ovf_reg",     32'(Overflow_Reg), 32'd0);
         chk("rst_epc",         EPC,              32'd0);
         chk("rst_return_pc",   Return_PC,        32'd4);
         chk("rst_nested",      32'(Nested),      32'd0);
         chk("rst_ovf_count",   32'(Ovf_Count),   32'd0);
         chk("rst_pc_vector",   PC_Vector,        32'h0000_0080);
      end
      @(negedge Clock);
      Flag_Valid = 1'b0; Overflow = 1'b0; Zero = 1'b0;
      Reset = 1'b0;
      model_reset();

      foreach (vecs[i]) begin
         drive(vecs[i].in_bits[4], vecs[i].in_bits[3], vecs[i].in_bits[2],
               vecs[i].in_bits[1], vecs[i].in_bits[0], vecs[i].pc);
         chk($sformatf("vec%0d_exc_req", i),  32'(Exc_Req),      32'(vecs[i].out_bits[4]));
         chk($sformatf("vec%0d_busy", i),     32'(Busy),         32'(vecs[i].out_bits[3]));
         chk($sformatf("vec%0d_nested", i),   32'(Nested),       32'(vecs[i].out_bits[2]));
         chk($sformatf("vec%0d_zero_reg", i), 32'(Zero_Reg),     32'(vecs[i].out_bits[1]));
         chk($sformatf("vec%0d_ovf_reg", i),  32'(Overflow_Reg), 32'(vecs[i].out_bits[0]));
         chk($sformatf("vec%0d_epc", i),      EPC,               vecs[i].epc);
         chk($sformatf("vec%0d_count", i),    32'(Ovf_Count),    32'(vecs[i].cnt));
         if (i == 1) chk("return_pc_0x44", Return_PC, 32'h0000_0044);
         if (i == 11) chk("return_pc_wrap", Return_PC, 32'h0000_0000);
      end

      // Asynchronous reset while a request is pending
      @(negedge Clock);
      Flag_Valid = 1'b0; Overflow = 1'b0; Zero = 1'b0; Exc_Ack = 1'b0; Eret = 1'b0;
      #1;
      chk("pre_reset_exc_req", 32'(Exc_Req), 32'd1);
      Reset = 1'b1;
      #1;
      chk("async_rst_exc_req",   32'(Exc_Req),   32'd0);
      chk("async_rst_busy",      32'(Busy),      32'd0);
      chk("async_rst_epc",       EPC,            32'd0);
      chk("async_rst_ovf_count", 32'(Ovf_Count), 32'd0);
      chk("async_rst_return_pc", Return_PC,      32'd4);
      @(negedge Clock);
      Reset = 1'b0;
      model_reset();

      // Saturation of the overflow counter
      for (int i = 0; i < 260; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000 + 32'(i));
      end
      chk("count_saturated", 32'(Ovf_Count), 32'd255);
      chk("sat_epc_first_fault", EPC, 32'h0000_1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/controle_de_excecao.md
# controle_de_excecao

Overflow-exception sequencer and flag register sitting directly downstream of the ALU flag detector. It latches the Zero/Overflow flags of every valid ALU operation and suppresses write-back of an overflowing result. On a signed overflow it saves the faulting PC into EPC and requests a redirect to the exception vector from the multicycle control unit. It then tracks the handler until return-from-exception.

## Interface
- WIDTH, 32, PC / EPC width in bits
- EXC_VECTOR, 32'h0000_0080, handler address driven on PC_Vector
- CNT_WIDTH, 8, width of saturating overflow counter

- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- Flag_Valid  in  1  ALU result and flags valid this cycle
- Overflow  in  1  overflow flag from detector
- Zero  in  1  zero flag from detector
- PC_Atual  in  WIDTH  PC of the instruction producing the flags
- Exc_Ack  in  1  control unit accepted the redirect
- Eret  in  1  return-from-exception executed
- Zero_Reg  out  1  registered Zero flag
- Overflow_Reg  out  1  registered Overflow flag
- Block_Write  out  1  combinational: suppress register-file write of current result
- Exc_Req  out  1  redirect request to control unit
- PC_Vector  out  WIDTH  constant EXC_VECTOR
- EPC  out  WIDTH  saved faulting PC
- Return_PC  out  WIDTH  EPC + 4, modulo 2^WIDTH
- Nested  out  1  overflow occurred while inside handler
- Ovf_Count  out  CNT_WIDTH  saturating overflow event count
- Busy  out  1  state != IDLE

## Operation
- Event: ovf_evt = Flag_Valid & Overflow.
- Flags: on every edge with Flag_Valid=1, Zero_Reg<=Zero and Overflow_Reg<=Overflow, in any state. Otherwise hold.
- Block_Write = ovf_evt, in any state. It is combinational and applies in the same cycle.
- Ovf_Count increments on every ovf_evt edge and saturates at 2^CNT_WIDTH-1.
- FSM states: IDLE, REQUEST, IN_HANDLER.
  - IDLE: ovf_evt -> EPC<=PC_Atual, go to REQUEST.
  - REQUEST: Exc_Req=1. Exc_Ack=1 -> IN_HANDLER. Otherwise stay. ovf_evt here counts only; EPC is unchanged.
  - IN_HANDLER: ovf_evt -> Nested<=1 and EPC unchanged. Eret=1 -> IDLE and Nested<=0.
- Exc_Ack outside REQUEST is ignored. Eret outside IN_HANDLER is ignored.
- Simultaneous Eret and ovf_evt in IN_HANDLER:
  - the FSM goes to IDLE;
  - the count increments;
  - Nested is cleared;
  - no new exception is raised. The overflow is lost except in the count.
- Simultaneous Exc_Ack and ovf_evt in REQUEST: the FSM goes to IN_HANDLER, the count increments, Nested stays 0.
- Return_PC = EPC + 4, truncated to WIDTH (EPC=FFFF_FFFC gives 0000_0000).

## Timing
- Reset values: state=IDLE, Zero_Reg=0, Overflow_Reg=0, EPC=0, Nested=0, Ovf_Count=0, Exc_Req=0, Busy=0. Return_PC=4 and PC_Vector=EXC_VECTOR.
- Reset asserted mid-sequence returns to IDLE immediately (asynchronous) and drops Exc_Req without an Ack.
- Latency: ovf_evt sampled at edge N gives Exc_Req=1 and EPC valid from edge N (visible in cycle N+1).
- Exc_Req is a level held until the edge where Exc_Ack=1. It falls after that edge.
- Eret sampled at edge M gives Busy=0 in cycle M+1. A new ovf_evt in cycle M+1 raises a new exception.
- Exc_Req, Busy and Nested are registered or decoded from state only. Block_Write is the only combinational path (Flag_Valid, Overflow -> Block_Write).

## Structure
- Shared package constants:
  - state encoding: IDLE=2'd0, REQUEST=2'd1, IN_HANDLER=2'd2; 2'd3 recovers to IDLE;
  - EXC_VECTOR default;
  - PC increment 4.
- One natural sub-module: contador_saturado (parameterised saturating up-counter with enable and async reset), used for Ovf_Count.
- Everything else is flat: one state register block, one next-state block, one datapath register block.

## Test plan
- Reset with Flag_Valid=1, Overflow=1 held -> all outputs at reset values; Block_Write=1 combinationally; no state change until Reset falls.
- Flag_Valid=1, Overflow=1, PC_Atual=0000_0040 at edge N. Then Exc_Ack=1 at N+3, then Eret at N+6. Required:
  - Block_Write=1 in cycle N;
  - EPC=0000_0040 and Exc_Req=1 in cycles N+1..N+3;
  - state IN_HANDLER from N+4;
  - Return_PC=0000_0044;
  - Busy=0 from N+7.
- In IN_HANDLER, ovf_evt with PC_Atual=0000_0100 -> EPC unchanged, Nested=1, Ovf_Count incremented. Eret -> Nested=0.
- Flag_Valid=1, Zero=1, Overflow=0 -> Zero_Reg=1, Overflow_Reg=0, no exception, Busy stays 0.
- 260 overflow events with CNT_WIDTH=8 -> Ovf_Count saturates at 255.
- EPC=FFFF_FFFC gives Return_PC=0000_0000. Reset asserted in REQUEST drops Exc_Req within the same cycle.
